// File: rtl/fifo_mw_mr.sv
// Multi-write / multi-read FIFO with first-word fall-through and optional same-cycle bypass.
// Write lanes are accepted in ascending lane order against the registered free count.
module fifo_mw_mr #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_W      = 4,
    parameter int NUM_R      = 2,
    parameter int BYPASS     = 1,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_W-1:0]            w_val,
    input  logic [NUM_W*FIFO_WIDTH-1:0] w_data,
    output logic [NUM_W-1:0]            w_acc,
    input  logic [NUM_R-1:0]            r_val,
    output logic [NUM_R*FIFO_WIDTH-1:0] r_data,
    output logic [NUM_R-1:0]            r_avail,
    output logic [CNT_WIDTH-1:0]        size,
    output logic [CNT_WIDTH-1:0]        free,
    output logic                        full,
    output logic                        empty,
    output logic                        ovf,
    input  logic                        clr_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SUM_W = CNT_WIDTH + 1;
    localparam logic [SUM_W-1:0]     DEPTH_S = SUM_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_WIDTH-1:0]  r_size;
    logic                  r_ovf;

    logic [CNT_WIDTH-1:0]  w_free;
    logic [CNT_WIDTH-1:0]  w_n_acc;
    logic [CNT_WIDTH-1:0]  w_n_rd;
    logic [CNT_WIDTH-1:0]  w_avail_cnt;
    logic [CNT_WIDTH-1:0]  w_rank [NUM_W];
    logic [FIFO_WIDTH-1:0] w_comp [NUM_W];
    logic [NUM_W-1:0]      w_acc_int;
    logic [NUM_R-1:0]      w_avail_int;

    // Any pointer sum here is below 2*DEPTH, so one conditional subtract suffices.
    function automatic logic [PTR_W-1:0] wrap_ptr(input logic [SUM_W-1:0] a);
        logic [SUM_W-1:0] t;
        t = (a >= DEPTH_S) ? (a - DEPTH_S) : a;
        return t[PTR_W-1:0];
    endfunction

    assign w_free = DEPTH_C - r_size;

    // Rank among valid lanes equals write offset for accepted lanes, since
    // only the lowest-ranked lanes are ever accepted.
    always_comb begin : accept_p
        logic [CNT_WIDTH-1:0] vcnt;
        logic                 acc;
        vcnt      = '0;
        acc       = 1'b0;
        w_n_acc   = '0;
        w_acc_int = '0;
        for (int i = 0; i < NUM_W; i++) begin
            w_rank[i]    = vcnt;
            acc          = rst_n & w_val[i] & (vcnt < w_free);
            w_acc_int[i] = acc;
            if (w_val[i]) vcnt = vcnt + CNT_WIDTH'(1);
            if (acc)      w_n_acc = w_n_acc + CNT_WIDTH'(1);
        end
    end

    always_comb begin : compact_p
        for (int j = 0; j < NUM_W; j++) begin
            w_comp[j] = '1;
            for (int i = 0; i < NUM_W; i++) begin
                if (w_acc_int[i] && (w_rank[i] == CNT_WIDTH'(j)))
                    w_comp[j] = w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign w_avail_cnt = (BYPASS != 0) ? (r_size + w_n_acc) : r_size;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_R; gi++) begin : g_rd
            logic [PTR_W-1:0]      w_rd_idx;
            logic [FIFO_WIDTH-1:0] w_lane;
            logic [CNT_WIDTH-1:0]  w_k;

            assign w_k              = CNT_WIDTH'(gi);
            assign w_rd_idx         = wrap_ptr(SUM_W'(r_head) + SUM_W'(gi));
            assign w_avail_int[gi]  = rst_n & (w_k < w_avail_cnt);

            // Lanes past the stored entries come straight from this cycle's accepted writes.
            always_comb begin
                w_lane = '1;
                if (w_avail_int[gi]) begin
                    if (w_k < r_size) begin
                        w_lane = r_mem[w_rd_idx];
                    end else begin
                        for (int j = 0; j < NUM_W; j++) begin
                            if ((w_k - r_size) == CNT_WIDTH'(j))
                                w_lane = w_comp[j];
                        end
                    end
                end
            end

            assign r_data[gi*FIFO_WIDTH +: FIFO_WIDTH] = w_lane;
        end
    endgenerate

    always_comb begin : read_p
        logic run;
        run    = 1'b1;
        w_n_rd = '0;
        for (int k = 0; k < NUM_R; k++) begin
            if (run && r_val[k] && w_avail_int[k]) w_n_rd = w_n_rd + CNT_WIDTH'(1);
            else                                   run    = 1'b0;
        end
    end

    // Bypassed entries are stored too; the matching head advance keeps occupancy exact.
    always_ff @(posedge clk) begin : mem_wr_p
        for (int i = 0; i < NUM_W; i++) begin
            if (w_acc_int[i])
                r_mem[wrap_ptr(SUM_W'(r_tail) + SUM_W'(w_rank[i]))] <= w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_p
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_size <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_head <= wrap_ptr(SUM_W'(r_head) + SUM_W'(w_n_rd));
            r_tail <= wrap_ptr(SUM_W'(r_tail) + SUM_W'(w_n_acc));
            r_size <= r_size + w_n_acc - w_n_rd;
            if (|(w_val & ~w_acc_int)) r_ovf <= 1'b1;
            else if (clr_ovf)          r_ovf <= 1'b0;
        end
    end

    assign w_acc   = w_acc_int;
    assign r_avail = w_avail_int;
    assign size    = r_size;
    assign free    = w_free;
    assign full    = (r_size == DEPTH_C);
    assign empty   = (r_size == '0);
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_fifo_mw_mr.sv
// Directed bench for fifo_mw_mr: stimulus pushes expected read data into a scoreboard,
// a negedge monitor pops and compares every element the DUT retires.
module tb_fifo_mw_mr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  w_val = '0;
    logic [31:0] w_data = '0;
    logic [1:0]  r_val = '0;
    logic        clr_ovf = 1'b0;
    logic [3:0]  w_acc;
    logic [15:0] r_data;
    logic [1:0]  r_avail;
    logic [3:0]  size, free;
    logic        full, empty, ovf;

    logic [3:0]  nb_w_val = '0;
    logic [31:0] nb_w_data = '0;
    logic [1:0]  nb_r_val = '0;
    logic [3:0]  nb_w_acc;
    logic [15:0] nb_r_data;
    logic [1:0]  nb_r_avail;
    logic [3:0]  nb_size, nb_free;
    logic        nb_full, nb_empty, nb_ovf;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    fifo_mw_mr #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .NUM_W(4), .NUM_R(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .w_val(w_val), .w_data(w_data), .w_acc(w_acc),
        .r_val(r_val), .r_data(r_data), .r_avail(r_avail), .size(size), .free(free),
        .full(full), .empty(empty), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    fifo_mw_mr #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .NUM_W(4), .NUM_R(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .w_val(nb_w_val), .w_data(nb_w_data), .w_acc(nb_w_acc),
        .r_val(nb_r_val), .r_data(nb_r_data), .r_avail(nb_r_avail), .size(nb_size), .free(nb_free),
        .full(nb_full), .empty(nb_empty), .ovf(nb_ovf), .clr_ovf(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] wv, input logic [31:0] wd, input logic [1:0] rv, input logic clr);
        w_val = wv; w_data = wd; r_val = rv; clr_ovf = clr;
    endtask

    task automatic show(input string tag);
        $display("%s: w_val=%b w_acc=%b r_val=%b r_avail=%b r_data=%h size=%0d free=%0d ovf=%b",
                 tag, w_val, w_acc, r_val, r_avail, r_data, size, free, ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every lane retired this cycle must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic run;
                run = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    if (run && r_val[k] && r_avail[k]) begin
                        if (sb.size() == 0) chk("rd_unexpected", 32'(r_data[k*8 +: 8]), 32'h1ff);
                        else chk("rd_data", 32'(r_data[k*8 +: 8]), 32'(sb.pop_front()));
                    end else begin
                        run = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int          msz;
        int          nacc;
        logic [31:0] wd;

        // Reset state
        tick();
        chk("rst_size", 32'(size), 32'd0);
        chk("rst_free", 32'(free), 32'd8);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ravail", 32'(r_avail), 32'd0);
        chk("rst_wacc", 32'(w_acc), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'hffff);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        // Sparse write with bypass
        drive(4'b1011, 32'hD3EEB1A0, 2'b00, 1'b0);
        sb.push_back(8'hA0); sb.push_back(8'hB1); sb.push_back(8'hD3);
        #2; show("wr1011");
        chk("w1_wacc", 32'(w_acc), 32'hB);
        chk("w1_ravail", 32'(r_avail), 32'h3);
        chk("w1_bypass", 32'(r_data), 32'hB1A0);
        tick();
        chk("w1_size", 32'(size), 32'd3);
        chk("w1_free", 32'(free), 32'd5);

        drive(4'b0111, 32'h0016F5E4, 2'b00, 1'b0);
        sb.push_back(8'hE4); sb.push_back(8'hF5); sb.push_back(8'h16);
        #2; show("wr0111");
        chk("w2_wacc", 32'(w_acc), 32'h7);
        tick();
        chk("w2_size", 32'(size), 32'd6);

        // Overflow: only two slots left
        drive(4'b1111, 32'h5A493827, 2'b00, 1'b0);
        sb.push_back(8'h27); sb.push_back(8'h38);
        #2; show("wr_ovf");
        chk("w3_wacc", 32'(w_acc), 32'h3);
        tick();
        chk("w3_size", 32'(size), 32'd8);
        chk("w3_full", 32'(full), 32'd1);
        chk("w3_free", 32'(free), 32'd0);
        chk("w3_ovf", 32'(ovf), 32'd1);

        drive(4'b0000, 32'h0, 2'b00, 1'b1);
        #2; show("clr_ovf");
        tick();
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Read and write while full: write refused, read proceeds
        drive(4'b1111, 32'h9E8D7C6B, 2'b11, 1'b0);
        #2; show("full_rw");
        chk("frw_wacc", 32'(w_acc), 32'h0);
        chk("frw_ravail", 32'(r_avail), 32'h3);
        tick();
        chk("frw_size", 32'(size), 32'd6);
        chk("frw_free", 32'(free), 32'd2);
        chk("frw_ovf", 32'(ovf), 32'd1);
        chk("frw_full", 32'(full), 32'd0);

        drive(4'b0000, 32'h0, 2'b11, 1'b1);
        #2; show("rd2");
        tick();
        chk("rd2_ovf", 32'(ovf), 32'd0);
        drive(4'b0000, 32'h0, 2'b11, 1'b0);
        #2; show("rd3");
        tick();
        chk("rd3_size", 32'(size), 32'd2);

        // Head now at index 6: sustained 4-write / 2-read burst with wrap-around
        msz = 2;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) wd[i*8 +: 8] = 8'(8'h40 + c*4 + i);
            nacc = ((8 - msz) < 4) ? (8 - msz) : 4;
            drive(4'b1111, wd, 2'b11, 1'b0);
            for (int i = 0; i < nacc; i++) sb.push_back(wd[i*8 +: 8]);
            #2; show("burst");
            chk("burst_wacc", 32'(w_acc), 32'((1 << nacc) - 1));
            tick();
            msz = msz + nacc - 2;
            chk("burst_size", 32'(size), 32'(msz));
        end
        chk("burst_ovf", 32'(ovf), 32'd1);

        // Drain
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 32'h0, 2'b11, 1'b1);
            #2; show("drain");
            tick();
        end
        chk("drain_size", 32'(size), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_sb_left", 32'(sb.size()), 32'd0);

        // Empty FIFO, non-contiguous read request
        drive(4'b0000, 32'h0, 2'b10, 1'b0);
        #2; show("empty_rd");
        chk("erd_ravail", 32'(r_avail), 32'd0);
        chk("erd_rdata", 32'(r_data), 32'hffff);
        tick();
        chk("erd_size", 32'(size), 32'd0);
        drive(4'b0000, 32'h0, 2'b00, 1'b0);

        // No-bypass instance: one write becomes visible a cycle later
        nb_w_val = 4'b0001; nb_w_data = 32'h0000005C;
        #2;
        $display("nb_wr: w_acc=%b r_avail=%b r_data=%h", nb_w_acc, nb_r_avail, nb_r_data);
        chk("nb_wacc", 32'(nb_w_acc), 32'h1);
        chk("nb_ravail0", 32'(nb_r_avail), 32'h0);
        chk("nb_rdata0", 32'(nb_r_data), 32'hffff);
        tick();
        nb_w_val = 4'b0000; nb_r_val = 2'b01;
        #2;
        $display("nb_rd: r_avail=%b r_data=%h size=%0d", nb_r_avail, nb_r_data, nb_size);
        chk("nb_ravail1", 32'(nb_r_avail), 32'h1);
        chk("nb_rdata1", 32'(nb_r_data), 32'hff5c);
        tick();
        nb_r_val = 2'b00;
        chk("nb_size", 32'(nb_size), 32'd0);

        // Reset pulse mid-burst
        drive(4'b1111, 32'h44332211, 2'b00, 1'b0);
        #2; show("pre_rst");
        tick();
        chk("prst_size", 32'(size), 32'd4);
        drive(4'b0011, 32'h00006655, 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1; show("in_rst");
        chk("arst_size", 32'(size), 32'd0);
        chk("arst_free", 32'(free), 32'd8);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ravail", 32'(r_avail), 32'd0);
        chk("arst_wacc", 32'(w_acc), 32'd0);
        chk("arst_rdata", 32'(r_data), 32'hffff);
        drive(4'b0000, 32'h0, 2'b00, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_size", 32'(size), 32'd0);

        drive(4'b0001, 32'h0000005A, 2'b00, 1'b0);
        sb.push_back(8'h5A);
        #2; show("wr_x");
        chk("x_ravail", 32'(r_avail), 32'h1);
        chk("x_bypass", 32'(r_data[7:0]), 32'h5A);
        tick();
        chk("x_size", 32'(size), 32'd1);
        drive(4'b0000, 32'h0, 2'b01, 1'b0);
        #2; show("rd_x");
        chk("x_stored", 32'(r_data[7:0]), 32'h5A);
        tick();
        chk("x_final_size", 32'(size), 32'd0);
        chk("x_sb_left", 32'(sb.size()), 32'd0);
        drive(4'b0000, 32'h0, 2'b00, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_mw_mr.md
Name: fifo_mw_mr

Overview:
Multi-port FIFO with first-word fall-through and optional same-cycle bypass. It accepts up to NUM_W writes and retires up to NUM_R reads per cycle. It is the parametrised successor to the two-write-port FIFO, used where one block produces several elements per cycle, such as per-packet segment fan-out. Unlike that FIFO, it never silently drops data: each write lane gets an explicit accept, overflow is flagged, and the full DEPTH is usable.

Parameters:
FIFO_WIDTH, 8, element width in bits
FIFO_DEPTH, 8, number of entries; any integer >= max(NUM_W, NUM_R), power of two not required
NUM_W, 4, write lanes per cycle (>= 1)
NUM_R, 2, read lanes per cycle (>= 1)
BYPASS, 1, 1: accepted writes are readable in the same cycle; 0: readable one cycle after the write
CNT_WIDTH, clogb2(FIFO_DEPTH)+1, width of the size and free counts

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_val  in  NUM_W  per-lane write request
w_data  in  NUM_W*FIFO_WIDTH  lane i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
w_acc  out  NUM_W  per-lane accept, combinational
r_val  in  NUM_R  per-lane read request
r_data  out  NUM_R*FIFO_WIDTH  lane k carries the element at head+k
r_avail  out  NUM_R  lane k holds valid data
size  out  CNT_WIDTH  stored entries
free  out  CNT_WIDTH  FIFO_DEPTH - size
full  out  1  size == FIFO_DEPTH
empty  out  1  size == 0
ovf  out  1  sticky overflow flag
clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Clocking and reset: single clock; asynchronous active-low reset.
- Reset: head = tail = 0, size = 0, ovf = 0. Resulting outputs: free = FIFO_DEPTH, empty = 1, full = 0, r_avail = 0, w_acc = 0, r_data all-ones. Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately. The first write after release lands at index 0.
- Write acceptance:
  - Valid lanes are ranked by ascending lane index. The lowest min(popcount(w_val), free) valid lanes get w_acc = 1.
  - Acceptance depends only on registered size. Same-cycle reads do not create room. There is no combinational path r_val -> w_acc.
  - n_acc = popcount(w_acc). Accepted lanes are compacted in rank order and written to tail, tail+1, ..., tail+n_acc-1, modulo FIFO_DEPTH.
- Read availability:
  - BYPASS=1: avail_cnt = size + n_acc.
  - BYPASS=0: avail_cnt = size.
  - r_avail[k] = (k < avail_cnt).
  - For k < size, r_data lane k = mem[(head+k) mod DEPTH].
  - For size <= k < avail_cnt, r_data lane k = accepted write of rank k - size (bypass).
  - Lanes with r_avail = 0 drive all-ones.
- Read consumption:
  - n_rd = count of leading ones of (r_val & r_avail), starting from lane 0.
  - A request that is non-contiguous or on an unavailable lane is ignored and has no side effect.
  - head advances by n_rd.
  - Bypassed entries that are read are still written to storage. The write and the head advance cancel, so occupancy stays consistent.
- Registered update each cycle:
  - size <= size + n_acc - n_rd. Never below 0 or above FIFO_DEPTH, by construction.
  - Pointer update is ptr + n; if the result is >= FIFO_DEPTH, subtract FIFO_DEPTH. This covers every n <= FIFO_DEPTH and any non-power-of-two depth.
- Flags: full, empty and free are decoded from the size register. They are glitch-free and valid from the cycle after the update.
- Overflow: ovf is set when any lane has w_val = 1 and w_acc = 0. It holds until clr_ovf. If set and clear occur in the same cycle, set wins.
- Simultaneous read and write when full: the write is refused (free = 0), the read proceeds, and the next cycle shows free = n_rd.
- Latency: with BYPASS=1, write to r_avail is 0 cycles. With BYPASS=0 it is 1 cycle. Read to updated size/free is 1 cycle.

Test Plan:
- Reset, then w_val=4'b1011 with data A,B,_,D, no reads. Same cycle: w_acc=1011, r_avail=11, r_data lanes = A,B (bypass). Next cycle: size=3, free=5.
- Continue to size=6, then w_val=4'b1111 -> w_acc=0011, ovf=1. Next cycle: size=8, full=1. Assert clr_ovf -> ovf=0 next cycle.
- At full, r_val=11 plus w_val=1111 -> w_acc=0000, head elements retired, ovf=1. Next cycle: size=6, free=2.
- With head at index 6, write 4 elements and read 2 per cycle over 20 cycles. Verify wrap-around and FIFO order via scoreboard, and that size never exceeds 8.
- Empty FIFO, r_val=10 only -> n_rd=0, r_data all-ones, size stays 0. Same with BYPASS=0 and one write: r_avail=00 this cycle, 01 next cycle.
- Pulse rst_n low mid-burst between clock edges -> outputs return to reset values immediately. Post-release write of X appears at r_data lane 0.
